// File: rtl/vga_monitor.sv
// VGA timing monitor: watches a TinyVGA-style output bus, locks onto the
// vsync edge, checks hsync/vsync/blanking against the configured timing and
// produces a rotating-XOR checksum of every completed frame.
module vga_monitor #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [7:0]  uo_out,
   output logic        locked,
   output logic [10:0] h_pos,
   output logic [9:0]  v_pos,
   output logic        frame_valid,
   output logic [15:0] frame_sum,
   output logic [15:0] frame_count,
   output logic        err_hsync,
   output logic        err_vsync,
   output logic        err_blank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {SEARCH, LOCKED} state_e;

   state_e      state_q, state_d;
   logic [10:0] hPos_q, hPos_d;
   logic [9:0]  vPos_q, vPos_d;
   logic [15:0] sum_q, sum_d;
   logic [15:0] frameSum_q, frameSum_d;
   logic [15:0] frameCount_q, frameCount_d;
   logic        frameValid_q, frameValid_d;
   logic        errH_q, errH_d;
   logic        errV_q, errV_d;
   logic        errB_q, errB_d;
   logic        prevVs_q, prevVs_d;

   // Decoded bus fields; sync levels are normalised to "asserted" polarity.
   logic       hsAct, vsAct, vsEdge;
   logic [5:0] rgb;
   logic       hsExp, vsExp, hsMis, vsMis, inActive, frameEnd;

   assign hsAct    = SYNC_ACTIVE_LOW ? ~uo_out[7] : uo_out[7];
   assign vsAct    = SYNC_ACTIVE_LOW ? ~uo_out[3] : uo_out[3];
   assign rgb      = {uo_out[0], uo_out[4], uo_out[1], uo_out[5], uo_out[2], uo_out[6]};
   assign vsEdge   = vsAct && !prevVs_q;
   assign hsExp    = (hPos_q >= HS_START) && (hPos_q < HS_END);
   assign vsExp    = (vPos_q >= VS_START) && (vPos_q < VS_END);
   assign hsMis    = hsAct != hsExp;
   assign vsMis    = vsAct != vsExp;
   assign inActive = (hPos_q < H_ACT_END) && (vPos_q < V_ACT_END);
   assign frameEnd = (hPos_q == H_LAST) && (vPos_q == V_LAST);

   // State and datapath registers, all cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SEARCH;
         hPos_q       <= '0;
         vPos_q       <= '0;
         sum_q        <= '0;
         frameSum_q   <= '0;
         frameCount_q <= '0;
         frameValid_q <= 1'b0;
         errH_q       <= 1'b0;
         errV_q       <= 1'b0;
         errB_q       <= 1'b0;
         prevVs_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         hPos_q       <= hPos_d;
         vPos_q       <= vPos_d;
         sum_q        <= sum_d;
         frameSum_q   <= frameSum_d;
         frameCount_q <= frameCount_d;
         frameValid_q <= frameValid_d;
         errH_q       <= errH_d;
         errV_q       <= errV_d;
         errB_q       <= errB_d;
         prevVs_q     <= prevVs_d;
      end
   end

   // Next state: lock on a vsync assertion edge, drop lock on any sync mismatch.
   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            SEARCH:  if (vsEdge) state_d = LOCKED;
            LOCKED:  if (hsMis || vsMis) state_d = SEARCH;
            default: state_d = SEARCH;
         endcase
      end
   end

   // Counters, checksum, frame reporting and sticky error flags.
   always_comb begin
      hPos_d       = hPos_q;
      vPos_d       = vPos_q;
      sum_d        = sum_q;
      frameSum_d   = frameSum_q;
      frameCount_d = frameCount_q;
      frameValid_d = 1'b0;
      errH_d       = errH_q;
      errV_d       = errV_q;
      errB_d       = errB_q;
      prevVs_d     = prevVs_q;
      if (ena) begin
         prevVs_d = vsAct;
         if (state_q == SEARCH) begin
            hPos_d = '0;
            vPos_d = '0;
            if (vsEdge) begin
               hPos_d = 11'd1;
               vPos_d = VS_START;
               sum_d  = '0;
            end
         end else begin
            if ((rgb != 6'd0) && !inActive) errB_d = 1'b1;
            if (hsMis || vsMis) begin
               errH_d = errH_q | hsMis;
               errV_d = errV_q | vsMis;
               hPos_d = '0;
               vPos_d = '0;
               sum_d  = '0;
            end else begin
               if (hPos_q == H_LAST) begin
                  hPos_d = '0;
                  vPos_d = (vPos_q == V_LAST) ? 10'd0 : vPos_q + 10'd1;
               end else begin
                  hPos_d = hPos_q + 11'd1;
               end
               if (inActive) sum_d = {sum_q[14:0], sum_q[15]} ^ {10'b0, rgb};
               if (frameEnd) begin
                  frameSum_d   = sum_q;
                  frameValid_d = 1'b1;
                  frameCount_d = frameCount_q + 16'd1;
                  sum_d        = '0;
               end
            end
         end
      end
   end

   assign locked      = (state_q == LOCKED);
   assign h_pos       = hPos_q;
   assign v_pos       = vPos_q;
   assign frame_valid = frameValid_q;
   assign frame_sum   = frameSum_q;
   assign frame_count = frameCount_q;
   assign err_hsync   = errH_q;
   assign err_vsync   = errV_q;
   assign err_blank   = errB_q;

endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor using a tiny 8x6 video timing.
module tb_vga_monitor;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic [7:0]  uo_out;
   logic        locked;
   logic [10:0] h_pos;
   logic [9:0]  v_pos;
   logic        frame_valid;
   logic [15:0] frame_sum;
   logic [15:0] frame_count;
   logic        err_hsync;
   logic        err_vsync;
   logic        err_blank;

   int passCount  = 0;
   int totalCount = 0;
   int fvSeen     = 0;
   int fvMark     = 0;

   // Video source state and fault knobs.
   int         gh = 0;
   int         gv = 0;
   logic [5:0] activeRgb   = 6'd0;
   logic       hsForceHigh = 1'b0;
   logic       rgbForce    = 1'b0;
   logic [5:0] rgbForceVal = 6'd0;

   vga_monitor #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .uo_out(uo_out),
      .locked(locked),
      .h_pos(h_pos),
      .v_pos(v_pos),
      .frame_valid(frame_valid),
      .frame_sum(frame_sum),
      .frame_count(frame_count),
      .err_hsync(err_hsync),
      .err_vsync(err_vsync),
      .err_blank(err_blank)
   );

   // Free-running pixel clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one pixel from the source (or garbage when gated), clock it, advance the source.
   task automatic applyStimulus();
      logic       hsPin, vsPin;
      logic [5:0] px;
      hsPin = !((gh == 5) || (gh == 6));
      vsPin = !(gv == 4);
      px    = ((gh < 4) && (gv < 3)) ? activeRgb : 6'd0;
      if (hsForceHigh) hsPin = 1'b1;
      if (rgbForce) px = rgbForceVal;
      if (!ena) uo_out = 8'h00;
      else uo_out = {hsPin, px[0], px[2], px[4], vsPin, px[1], px[3], px[5]};
      @(posedge clk);
      #1;
      if (frame_valid) fvSeen++;
      if (ena) begin
         if (gh == 7) begin
            gh = 0;
            gv = (gv == 5) ? 0 : gv + 1;
         end else begin
            gh = gh + 1;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      uo_out = 8'h88;
      #1;
      checkOutput("reset_locked", 32'(locked), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("reset_hpos", 32'(h_pos), 32'd0);
      checkOutput("reset_vpos", 32'(v_pos), 32'd0);
      checkOutput("reset_fcount", 32'(frame_count), 32'd0);
      checkOutput("reset_fsum", 32'(frame_sum), 32'd0);
      checkOutput("reset_errs", 32'({err_hsync, err_vsync, err_blank, frame_valid}), 32'd0);

      // Lock on the first vsync falling edge.
      rst_n = 1'b1;
      gh = 0; gv = 0;
      ticks(32);
      checkOutput("prelock_locked", 32'(locked), 32'd0);
      checkOutput("search_hpos", 32'(h_pos), 32'd0);
      applyStimulus();
      checkOutput("lock_locked", 32'(locked), 32'd1);
      checkOutput("lock_hpos", 32'(h_pos), 32'd1);
      checkOutput("lock_vpos", 32'(v_pos), 32'd4);
      ticks(15);
      checkOutput("first_fv", 32'(frame_valid), 32'd1);
      checkOutput("first_fcount", 32'(frame_count), 32'd1);
      checkOutput("first_fsum", 32'(frame_sum), 32'd0);
      checkOutput("wrap_pos", 32'({h_pos, v_pos}), 32'd0);

      // Full frame with every active pixel = 1.
      activeRgb = 6'h01;
      applyStimulus();
      checkOutput("fv_one_cycle", 32'(frame_valid), 32'd0);
      ticks(46);
      checkOutput("fv_not_early", 32'(frame_valid), 32'd0);
      checkOutput("still_locked", 32'(locked), 32'd1);
      applyStimulus();
      checkOutput("sum_fv", 32'(frame_valid), 32'd1);
      checkOutput("sum_value", 32'(frame_sum), 32'h0FFF);
      checkOutput("sum_fcount", 32'(frame_count), 32'd2);

      // Enable gating mid-line with hostile bus contents.
      ticks(2);
      ena = 1'b0;
      ticks(10);
      checkOutput("gate_hpos", 32'(h_pos), 32'd2);
      checkOutput("gate_vpos", 32'(v_pos), 32'd0);
      checkOutput("gate_flags", 32'({err_hsync, err_vsync, err_blank, frame_valid}), 32'd0);
      checkOutput("gate_locked", 32'(locked), 32'd1);
      ena = 1'b1;
      ticks(46);
      checkOutput("gate_fv", 32'(frame_valid), 32'd1);
      checkOutput("gate_sum", 32'(frame_sum), 32'h0FFF);
      checkOutput("gate_fcount", 32'(frame_count), 32'd3);

      // Non-zero colour in horizontal blanking.
      ticks(5);
      rgbForce = 1'b1; rgbForceVal = 6'h3F;
      applyStimulus();
      rgbForce = 1'b0;
      checkOutput("blank_err", 32'(err_blank), 32'd1);
      checkOutput("blank_locked", 32'(locked), 32'd1);
      ticks(42);
      checkOutput("blank_fv", 32'(frame_valid), 32'd1);
      checkOutput("blank_sum", 32'(frame_sum), 32'h0FFF);
      checkOutput("blank_fcount", 32'(frame_count), 32'd4);
      checkOutput("blank_hs_clean", 32'({err_hsync, err_vsync}), 32'd0);

      // Missing hsync pulse, then relock.
      ticks(5);
      hsForceHigh = 1'b1;
      fvMark = fvSeen;
      applyStimulus();
      hsForceHigh = 1'b0;
      checkOutput("hs_err", 32'(err_hsync), 32'd1);
      checkOutput("hs_unlocked", 32'(locked), 32'd0);
      checkOutput("hs_vs_clean", 32'(err_vsync), 32'd0);
      ticks(26);
      checkOutput("hs_wait_locked", 32'(locked), 32'd0);
      checkOutput("hs_no_fv", 32'(fvSeen - fvMark), 32'd0);
      applyStimulus();
      checkOutput("hs_relock", 32'(locked), 32'd1);
      checkOutput("hs_relock_vpos", 32'(v_pos), 32'd4);
      ticks(15);
      checkOutput("hs_fv", 32'(frame_valid), 32'd1);
      checkOutput("hs_fcount", 32'(frame_count), 32'd5);
      checkOutput("hs_sticky", 32'(err_hsync), 32'd1);

      // Reset in the middle of a frame.
      ticks(10);
      checkOutput("pre_rst_vpos", 32'(v_pos), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_pos", 32'({h_pos, v_pos}), 32'd0);
      checkOutput("rst_fcount", 32'(frame_count), 32'd0);
      checkOutput("rst_fsum", 32'(frame_sum), 32'd0);
      checkOutput("rst_errs", 32'({err_hsync, err_vsync, err_blank}), 32'd0);
      ticks(2);
      rst_n = 1'b1;
      fvMark = fvSeen;
      ticks(20);
      checkOutput("rst_wait_locked", 32'(locked), 32'd0);
      checkOutput("rst_no_fv", 32'(fvSeen - fvMark), 32'd0);
      applyStimulus();
      checkOutput("rst_relock", 32'(locked), 32'd1);
      ticks(15);
      checkOutput("rst_fv", 32'(frame_valid), 32'd1);
      checkOutput("rst_fcount_after", 32'(frame_count), 32'd1);
      checkOutput("rst_fsum_after", 32'(frame_sum), 32'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
